// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: RV32I load/store bridge onto NUM_SLAVES word-addressed slaves.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing misaligned accesses.
module lsu_bus_bridge #(
  parameter int AWIDTH     = 12,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 28
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [31:0]             rsp_rdata,
  output logic [NUM_SLAVES-1:0]   bus_cs_n,
  output logic                    bus_we,
  output logic [AWIDTH-1:0]       bus_addr,
  output logic [3:0]              bus_be,
  output logic [31:0]             bus_wdata,
  input  logic [NUM_SLAVES*32-1:0] bus_rdata,
  input  logic [NUM_SLAVES-1:0]   bus_ready
);
  localparam int SELW = 32 - SEL_LSB;
  localparam int SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, CAPT} state_e;

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              first_q, first_d;
  logic [SW-1:0]     sel_q;
  logic [AWIDTH-1:0] addr_q;
  logic              we_q, split_q;
  logic [7:0]        be_q;
  logic [63:0]       wd_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [31:0]       lo_q;

  logic [SELW-1:0] region;
  logic [1:0]      off;
  logic [3:0]      smask;
  logic            f3_ok, reg_ok, mis_err, split, req_err;
  logic [7:0]      be64;
  logic [63:0]     wd64;
  logic            accept, capt_lo;
  logic [31:0]     rd_sel, shr, ext;
  logic            rdy_sel, beat;
  logic [63:0]     d64;
  logic            unused_addr;

  assign unused_addr = ^req_addr[SEL_LSB-1:AWIDTH+2];

  always_comb begin
    region = req_addr[31:SEL_LSB];
    off    = req_addr[1:0];
    case (req_funct3[1:0])
      2'b00:   smask = 4'b0001;
      2'b01:   smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
    f3_ok  = req_we ? (req_funct3 <= 3'b010)
                    : (req_funct3[1:0] != 2'b11 && req_funct3 != 3'b110);
    reg_ok = {{SEL_LSB{1'b0}}, region} < 32'(NUM_SLAVES);
    be64   = {4'b0000, smask} << off;
    wd64   = {32'b0, req_wdata} << {off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    split   = |be64[7:4];
    mis_err = 1'b0;
`else
    split   = 1'b0;
    mis_err = |(off & {smask[3], smask[1]});
`endif
    req_err = !f3_ok || !reg_ok || mis_err;
  end

  always_comb begin
    rd_sel  = '0;
    rdy_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SW'(i)) begin
        rd_sel  = bus_rdata[32*i +: 32];
        rdy_sel = bus_ready[i];
      end
    end
  end

  assign beat      = (state_q == BEAT0) || (state_q == BEAT1);
  assign req_ready = (state_q == IDLE);
  assign bus_we    = beat && we_q;
  assign bus_addr  = (state_q == BEAT1) ? addr_q + AWIDTH'(1) : addr_q;
  assign bus_wdata = (state_q == BEAT1) ? wd_q[63:32] : wd_q[31:0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    bus_be = 4'b0000;
    if (state_q == BEAT0) bus_be = be_q[3:0];
    if (state_q == BEAT1) bus_be = be_q[7:4];
    for (int i = 0; i < NUM_SLAVES; i++)
      bus_cs_n[i] = !(beat && sel_q == SW'(i));
  end

  // Beat-0 word sits in lo_q when the access was split.
  always_comb begin
    d64 = split_q ? {rd_sel, lo_q} : {32'b0, rd_sel};
    shr = 32'(d64 >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ext = {{24{shr[7]}}, shr[7:0]};
      3'b001:  ext = {{16{shr[15]}}, shr[15:0]};
      3'b100:  ext = {24'b0, shr[7:0]};
      3'b101:  ext = {16'b0, shr[15:0]};
      default: ext = shr;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    first_d     = 1'b0;
    accept      = 1'b0;
    capt_lo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (rdy_sel) begin
          state_d = split_q ? BEAT1 : CAPT;
          first_d = split_q;
        end
      end
      BEAT1: begin
        capt_lo = first_q;
        if (rdy_sel) state_d = CAPT;
      end
      CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'b0 : ext;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      first_q     <= first_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      split_q <= 1'b0;
    end else if (accept) begin
      sel_q   <= region[SW-1:0];
      addr_q  <= req_addr[AWIDTH+1:2];
      we_q    <= req_we;
      be_q    <= be64;
      wd_q    <= wd64;
      f3_q    <= req_funct3;
      off_q   <= off;
      split_q <= split;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       lo_q <= '0;
    else if (capt_lo) lo_q <= rd_sel;
  end
endmodule
